// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin payout engine for a three-tube hopper.
// A latched change amount is paid one coin at a time over a valid/ack
// handshake, largest denomination first, skipping empty tubes. Reports
// per-tube counts, a one-cycle done pulse and a fault on inexact change.
module change_dispenser #(
  parameter int unsigned DEN_HI     = 10,
  parameter int unsigned DEN_MID    = 5,
  parameter int unsigned DEN_LO     = 1,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] change_in,
  input  logic [2:0] tube_empty,
  input  logic       eject_ack,
  input  logic       clear_fault,
  output logic       eject_valid,
  output logic [1:0] eject_sel,
  output logic [7:0] remaining,
  output logic [7:0] cnt_hi,
  output logic [7:0] cnt_mid,
  output logic [7:0] cnt_lo,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  localparam int unsigned GW       = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam int unsigned GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;
  localparam logic [7:0]  V_HI     = 8'(DEN_HI);
  localparam logic [7:0]  V_MID    = 8'(DEN_MID);
  localparam logic [7:0]  V_LO     = 8'(DEN_LO);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EJECT,
    S_GAP,
    S_DONE,
    S_FAULT
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          valid_d;
  logic [1:0]    sel_d;
  logic [7:0]    rem_d, hi_d, mid_d, lo_d;
  logic          busy_d, done_d, fault_d;
  logic [7:0]    coin_val;

  // Value of the coin currently being ejected
  always_comb begin
    coin_val = V_LO;
    case (eject_sel)
      2'd2:    coin_val = V_HI;
      2'd1:    coin_val = V_MID;
      default: coin_val = V_LO;
    endcase
  end

  // Next-state and next-output computation; every output is registered
  // below, so flags are derived from the state being entered.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    valid_d = eject_valid;
    sel_d   = eject_sel;
    rem_d   = remaining;
    hi_d    = cnt_hi;
    mid_d   = cnt_mid;
    lo_d    = cnt_lo;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = change_in;
          hi_d    = '0;
          mid_d   = '0;
          lo_d    = '0;
          state_d = S_SELECT;
        end
      end

      S_SELECT: begin
        if (remaining == '0) begin
          state_d = S_DONE;
        end else if (remaining >= V_HI && !tube_empty[2]) begin
          sel_d   = 2'd2;
          valid_d = 1'b1;
          state_d = S_EJECT;
        end else if (remaining >= V_MID && !tube_empty[1]) begin
          sel_d   = 2'd1;
          valid_d = 1'b1;
          state_d = S_EJECT;
        end else if (remaining >= V_LO && !tube_empty[0]) begin
          sel_d   = 2'd0;
          valid_d = 1'b1;
          state_d = S_EJECT;
        end else begin
          state_d = S_FAULT;
        end
      end

      S_EJECT: begin
        if (eject_valid && eject_ack) begin
          rem_d   = remaining - coin_val;
          valid_d = 1'b0;
          case (eject_sel)
            2'd2:    hi_d  = cnt_hi + 8'd1;
            2'd1:    mid_d = cnt_mid + 8'd1;
            default: lo_d  = cnt_lo + 8'd1;
          endcase
          if (GAP_CYCLES == 0) begin
            state_d = S_SELECT;
          end else begin
            gap_d   = '0;
            state_d = S_GAP;
          end
        end
      end

      S_GAP: begin
        if (gap_q == GW'(GAP_LAST)) begin
          state_d = S_SELECT;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      S_FAULT: begin
        if (clear_fault) begin
          rem_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    fault_d = (state_d == S_FAULT);
  end

  // State, gap counter and registered outputs with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gap_q       <= '0;
      eject_valid <= 1'b0;
      eject_sel   <= '0;
      remaining   <= '0;
      cnt_hi      <= '0;
      cnt_mid     <= '0;
      cnt_lo      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      eject_valid <= valid_d;
      eject_sel   <= sel_d;
      remaining   <= rem_d;
      cnt_hi      <= hi_d;
      cnt_mid     <= mid_d;
      cnt_lo      <= lo_d;
      busy        <= busy_d;
      done        <= done_d;
      fault       <= fault_d;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus random
// payouts compared against a denomination-count reference model.
module tb_change_dispenser;

  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, eject_ack, clear_fault;
  logic [7:0] change_in;
  logic [2:0] tube_empty;
  logic       eject_valid, busy, done, fault;
  logic [1:0] eject_sel;
  logic [7:0] remaining, cnt_hi, cnt_mid, cnt_lo;

  logic       start2, ack2;
  logic [7:0] change2;
  logic       v2, busy2, done2, fault2;
  logic [1:0] sel2;
  logic [7:0] rem2, hi2, mid2, lo2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  change_dispenser #(.DEN_HI(10), .DEN_MID(5), .DEN_LO(1), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .change_in(change_in),
    .tube_empty(tube_empty), .eject_ack(eject_ack), .clear_fault(clear_fault),
    .eject_valid(eject_valid), .eject_sel(eject_sel), .remaining(remaining),
    .cnt_hi(cnt_hi), .cnt_mid(cnt_mid), .cnt_lo(cnt_lo),
    .busy(busy), .done(done), .fault(fault)
  );

  change_dispenser #(.DEN_HI(10), .DEN_MID(5), .DEN_LO(1), .GAP_CYCLES(0)) dut_nogap (
    .clk(clk), .rst(rst), .start(start2), .change_in(change2),
    .tube_empty(3'b000), .eject_ack(ack2), .clear_fault(1'b0),
    .eject_valid(v2), .eject_sel(sel2), .remaining(rem2),
    .cnt_hi(hi2), .cnt_mid(mid2), .cnt_lo(lo2),
    .busy(busy2), .done(done2), .fault(fault2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Coin value by tube index
  function automatic int den(input int s);
    if (s == 2) return 10;
    if (s == 1) return 5;
    return 1;
  endfunction

  // One complete transaction on the main DUT checked against the model.
  // hold_first: cycles to withhold ack on the first coin (0 = random 0..3).
  // poke: pulse start with a bogus amount while ack is withheld.
  task automatic run_txn(input int c, input logic [2:0] m, input int hold_first, input bit poke);
    int q[$];
    int nh, nm, nl, left, rem_exp, k, exp_k, h, s;
    bit fin, first, exp_fault;

    // Reference: greedy payout with a fixed set of usable tubes reduces to
    // taking as many of each usable coin as fit, largest first.
    left = c;
    nh = m[2] ? 0 : left / 10; left = left - nh * 10;
    nm = m[1] ? 0 : left / 5;  left = left - nm * 5;
    nl = m[0] ? 0 : left;      left = left - nl;
    exp_fault = (left != 0);
    for (int i = 0; i < nh; i++) q.push_back(2);
    for (int i = 0; i < nm; i++) q.push_back(1);
    for (int i = 0; i < nl; i++) q.push_back(0);
    rem_exp = c;

    start = 1'b1; change_in = 8'(c); tube_empty = m;
    tick();
    start = 1'b0; change_in = 8'($urandom);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b want 1", busy); end

    fin = 0; first = 1;
    while (!fin) begin
      exp_k = first ? 1 : GAP + 1;
      k = 0;
      while (eject_valid !== 1'b1 && done !== 1'b1 && fault !== 1'b1 && k < 400) begin
        tick(); k++;
      end
      checks++;
      if (k != exp_k) begin errors++; $display("FAIL event_latency: got %0d cycles want %0d (change %0d)", k, exp_k, c); end
      if (k >= 400) begin
        fin = 1;
      end else if (eject_valid === 1'b1) begin
        s = (q.size() > 0) ? q.pop_front() : -1;
        checks++;
        if (int'(eject_sel) != s) begin errors++; $display("FAIL eject_sel: got %0d want %0d (change %0d)", eject_sel, s, c); end
        h = (first && hold_first > 0) ? hold_first : int'($urandom_range(0, 3));
        for (int i = 0; i < h; i++) begin
          if (poke) begin start = 1'b1; change_in = 8'd99; end
          tube_empty = 3'($urandom);
          tick();
          checks++;
          if (eject_valid !== 1'b1 || int'(eject_sel) != s) begin
            errors++; $display("FAIL hold_stable: got valid=%b sel=%0d want valid=1 sel=%0d", eject_valid, eject_sel, s);
          end
        end
        start = 1'b0; tube_empty = m;
        eject_ack = 1'b1;
        tick();
        eject_ack = 1'b0;
        if (s >= 0) rem_exp = rem_exp - den(s);
        checks++;
        if (eject_valid !== 1'b0 || int'(remaining) != rem_exp) begin
          errors++; $display("FAIL after_ack: got valid=%b rem=%0d want valid=0 rem=%0d", eject_valid, remaining, rem_exp);
        end
        first = 0;
      end else if (done === 1'b1) begin
        checks++;
        if (exp_fault || q.size() != 0) begin errors++; $display("FAIL done_early: got done=1 want fault=%b coins_left=%0d", exp_fault, q.size()); end
        checks++;
        if (int'(cnt_hi) != nh || int'(cnt_mid) != nm || int'(cnt_lo) != nl || remaining !== 8'd0 || fault !== 1'b0) begin
          errors++; $display("FAIL done_counts: got hi=%0d mid=%0d lo=%0d rem=%0d want %0d %0d %0d 0", cnt_hi, cnt_mid, cnt_lo, remaining, nh, nm, nl);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_pulse: got done=%b busy=%b want 0 0", done, busy); end
        fin = 1;
      end else begin
        checks++;
        if (!exp_fault) begin errors++; $display("FAIL unexpected_fault: got fault=1 want 0 (change %0d mask %b)", c, m); end
        checks++;
        if (int'(remaining) != left || int'(cnt_hi) != nh || int'(cnt_mid) != nm || int'(cnt_lo) != nl || busy !== 1'b1) begin
          errors++; $display("FAIL fault_state: got rem=%0d hi=%0d mid=%0d lo=%0d busy=%b want %0d %0d %0d %0d 1", remaining, cnt_hi, cnt_mid, cnt_lo, busy, left, nh, nm, nl);
        end
        tick(); tick();
        checks++;
        if (fault !== 1'b1) begin errors++; $display("FAIL fault_hold: got %b want 1", fault); end
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        checks++;
        if (fault !== 1'b0 || busy !== 1'b0 || remaining !== 8'd0) begin
          errors++; $display("FAIL fault_clear: got fault=%b busy=%b rem=%0d want 0 0 0", fault, busy, remaining);
        end
        checks++;
        if (int'(cnt_hi) != nh || int'(cnt_mid) != nm || int'(cnt_lo) != nl) begin
          errors++; $display("FAIL counts_after_clear: got %0d %0d %0d want %0d %0d %0d", cnt_hi, cnt_mid, cnt_lo, nh, nm, nl);
        end
        fin = 1;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (eject_valid !== 1'b0 || eject_sel !== 2'd0 || remaining !== 8'd0 || cnt_hi !== 8'd0 ||
        cnt_mid !== 8'd0 || cnt_lo !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || fault !== 1'b0) begin
      errors++; $display("FAIL reset_state: got v=%b sel=%0d rem=%0d busy=%b done=%b fault=%b want all 0", eject_valid, eject_sel, remaining, busy, done, fault);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    run_txn(18, 3'b000, 1, 0);
    run_txn(20, 3'b100, 0, 0);
    run_txn(3, 3'b001, 0, 0);
    run_txn(0, 3'b000, 0, 0);
  endtask

  task automatic test_ack_hold();
    run_txn(7, 3'b000, 10, 1);
  endtask

  task automatic test_reset_mid();
    int k;
    start = 1'b1; change_in = 8'd15; tube_empty = 3'b000;
    tick();
    start = 1'b0;
    k = 0;
    while (eject_valid !== 1'b1 && k < 20) begin tick(); k++; end
    checks++;
    if (eject_valid !== 1'b1) begin errors++; $display("FAIL reset_mid_setup: got valid=%b want 1", eject_valid); end
    rst = 1'b1;
    #1;
    checks++;
    if (eject_valid !== 1'b0 || remaining !== 8'd0 || busy !== 1'b0 || eject_sel !== 2'd0 ||
        cnt_hi !== 8'd0 || cnt_mid !== 8'd0 || cnt_lo !== 8'd0 || done !== 1'b0 || fault !== 1'b0) begin
      errors++; $display("FAIL async_reset: got v=%b rem=%0d busy=%b want 0 0 0", eject_valid, remaining, busy);
    end
    #2;
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || eject_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got busy=%b v=%b want 0 0", busy, eject_valid); end
    run_txn(5, 3'b000, 0, 0);
  endtask

  task automatic test_no_gap();
    start2 = 1'b1; change2 = 8'd2;
    tick();
    start2 = 1'b0;
    tick();
    checks++;
    if (v2 !== 1'b1 || sel2 !== 2'd0) begin errors++; $display("FAIL nogap_first: got v=%b sel=%0d want 1 0", v2, sel2); end
    ack2 = 1'b1; tick(); ack2 = 1'b0;
    checks++;
    if (v2 !== 1'b0 || rem2 !== 8'd1 || lo2 !== 8'd1) begin errors++; $display("FAIL nogap_ack1: got v=%b rem=%0d lo=%0d want 0 1 1", v2, rem2, lo2); end
    tick();
    checks++;
    if (v2 !== 1'b1 || sel2 !== 2'd0) begin errors++; $display("FAIL nogap_rise: got v=%b sel=%0d want 1 0", v2, sel2); end
    ack2 = 1'b1; tick(); ack2 = 1'b0;
    checks++;
    if (v2 !== 1'b0 || rem2 !== 8'd0 || lo2 !== 8'd2 || done2 !== 1'b0) begin errors++; $display("FAIL nogap_ack2: got v=%b rem=%0d lo=%0d done=%b want 0 0 2 0", v2, rem2, lo2, done2); end
    tick();
    checks++;
    if (done2 !== 1'b1 || busy2 !== 1'b1 || hi2 !== 8'd0 || mid2 !== 8'd0 || fault2 !== 1'b0) begin
      errors++; $display("FAIL nogap_done: got done=%b busy=%b hi=%0d mid=%0d fault=%b want 1 1 0 0 0", done2, busy2, hi2, mid2, fault2);
    end
    tick();
    checks++;
    if (done2 !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL nogap_idle: got done=%b busy=%b want 0 0", done2, busy2); end
  endtask

  task automatic test_random();
    logic [2:0] m;
    for (int t = 0; t < 25; t++) begin
      m = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom);
      run_txn(int'($urandom_range(0, 120)), m, 0, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; eject_ack = 1'b0; clear_fault = 1'b0;
    change_in = '0; tube_empty = '0;
    start2 = 1'b0; ack2 = 1'b0; change2 = '0;
    test_reset();
    test_directed();
    test_ack_hold();
    test_reset_mid();
    test_no_gap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Payout back-end for the vending controller. It accepts a change amount when a sale completes and ejects coins one at a time to a three-tube coin hopper using a valid/ack handshake. Coins are chosen greedily, largest denomination first, and empty tubes are skipped. It reports per-denomination coin counts, a one-cycle done pulse, and a fault if exact change cannot be paid.

Parameters:
DEN_HI, 10, value of high coin (tube 2)
DEN_MID, 5, value of mid coin (tube 1)
DEN_LO, 1, value of low coin (tube 0)
GAP_CYCLES, 4, idle cycles between ack and next selection (0 allowed)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request payout; sampled only in IDLE
change_in  in  8  amount to pay, unsigned; latched on accepted start
tube_empty  in  3  bit i high = tube i has no coins; sampled in SELECT
eject_ack  in  1  hopper accepted current coin
clear_fault  in  1  leave FAULT state
eject_valid  out  1  coin request pending
eject_sel  out  2  tube index 0..2, valid while eject_valid
remaining  out  8  amount still owed
cnt_hi, cnt_mid, cnt_lo  out  8 each  coins ejected this transaction
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse, payout complete
fault  out  1  high while in FAULT

Behaviour:
- Reset (async, any state, mid-handshake included): state IDLE; all outputs 0; gap counter 0. eject_valid drops immediately.
- All outputs are registered.
- IDLE: if start=1, latch remaining<=change_in, clear all three counts, go to SELECT next cycle. start is ignored in every other state.
- SELECT (one cycle):
  - remaining==0: go to DONE.
  - else remaining>=DEN_HI and !tube_empty[2]: pick tube 2.
  - else remaining>=DEN_MID and !tube_empty[1]: pick tube 1.
  - else remaining>=DEN_LO and !tube_empty[0]: pick tube 0.
  - On a pick: register eject_sel, set eject_valid=1, go to EJECT.
  - If no tube qualifies: go to FAULT.
- EJECT: eject_valid and eject_sel stay stable until eject_ack=1.
  - In the ack cycle: remaining -= chosen value, increment the matching count, clear eject_valid.
  - Then go to GAP, or straight to SELECT if GAP_CYCLES==0.
  - Ack while eject_valid=0 is ignored.
- GAP: counts GAP_CYCLES cycles, then goes to SELECT.
- DONE: done=1 for exactly one cycle; busy=1; next state IDLE.
- FAULT: fault=1, busy=1. remaining and counts hold the partial result.
  - clear_fault=1 returns to IDLE with remaining cleared to 0.
  - Counts hold until the next accepted start.
- Arithmetic:
  - Subtraction never underflows, because a tube is picked only when remaining is at least its value.
  - Counts are 8-bit and wrap modulo 256; a wrap cannot occur with DEN_LO>=1 and an 8-bit change.
- change_in=0: IDLE -> SELECT -> DONE, no ejects, done pulse 2 cycles after start.
- tube_empty changing during EJECT does not abort the pending coin; it takes effect at the next SELECT.

Test Plan:
- Start, change 18, no tubes empty, ack 1 cycle after each valid -> sel sequence 2,1,0,0,0; cnt_hi=1, cnt_mid=1, cnt_lo=3; remaining 0; single done pulse; busy low after.
- Change 20, tube 2 empty -> four tube-1 ejects; cnt_mid=4, cnt_hi=0; done pulses.
- Change 3, tube 0 empty -> no eject; fault=1, remaining=3; clear_fault -> IDLE, fault=0, remaining=0.
- Change 7, ack withheld 10 cycles -> eject_valid=1 and eject_sel=1 held stable throughout; start pulses during this window are ignored.
- Assert rst while eject_valid=1 (change 15) -> all outputs 0 without waiting for a clock edge; a later start with change 5 completes normally, cnt_mid=1.
- GAP_CYCLES=0, change 2 -> consecutive eject_valid rises 1 cycle after each ack (ack, SELECT, EJECT); done after second coin.
